// File: rtl/nav_pkg.sv
// Shared navigation-datapath types and defaults for the divider arbiter.
package nav_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int BIN_POS    = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after `last`.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Scan last+1, last+2, ... modulo NUM_REQ; the first hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned off = 1; off <= unsigned'(NUM_REQ); off++) begin
      cand = IDX_W'((32'(last) + off) % unsigned'(NUM_REQ));
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sequencer sharing one fixed-point divider between requesters,
// with a watchdog that aborts a divider that never finishes.
module div_arbiter #(
  parameter int DATA_WIDTH = nav_pkg::DATA_WIDTH,
  parameter int NUM_REQ    = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_lhs,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rhs,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          resp_singular,
  output logic                          resp_timeout,
  output logic                          busy,
  output logic                          div_rst,
  output logic [DATA_WIDTH-1:0]         div_lhs,
  output logic [DATA_WIDTH-1:0]         div_rhs,
  input  logic                          div_complete,
  input  logic                          div_singular,
  input  logic [DATA_WIDTH-1:0]         div_out
);

  import nav_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT);

  arb_state_t              state, state_next;
  logic [IDX_W-1:0]        last, last_next;
  logic [IDX_W-1:0]        id, id_next;
  logic [WD_W-1:0]         wd, wd_next;
  logic [NUM_REQ-1:0]      grant_next, resp_valid_next;
  logic [DATA_WIDTH-1:0]   resp_data_next, lhs_next, rhs_next;
  logic                    sing_next, tmo_next, div_rst_next;
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign busy = (state != ARB_IDLE);

  // Register all state and the registered outputs; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      last          <= IDX_W'(NUM_REQ - 1);
      id            <= '0;
      wd            <= '0;
      grant         <= '0;
      resp_valid    <= '0;
      resp_data     <= '0;
      resp_singular <= 1'b0;
      resp_timeout  <= 1'b0;
      div_rst       <= 1'b1;
      div_lhs       <= '0;
      div_rhs       <= '0;
    end else begin
      state         <= state_next;
      last          <= last_next;
      id            <= id_next;
      wd            <= wd_next;
      grant         <= grant_next;
      resp_valid    <= resp_valid_next;
      resp_data     <= resp_data_next;
      resp_singular <= sing_next;
      resp_timeout  <= tmo_next;
      div_rst       <= div_rst_next;
      div_lhs       <= lhs_next;
      div_rhs       <= rhs_next;
    end
  end

  // Next-state and next-output logic; pulses default low, data holds.
  always_comb begin
    state_next      = state;
    last_next       = last;
    id_next         = id;
    wd_next         = wd;
    grant_next      = '0;
    resp_valid_next = '0;
    resp_data_next  = resp_data;
    sing_next       = resp_singular;
    tmo_next        = resp_timeout;
    div_rst_next    = div_rst;
    lhs_next        = div_lhs;
    rhs_next        = div_rhs;
    unique case (state)
      ARB_IDLE: begin
        div_rst_next = 1'b1;
        if (pick_valid) begin
          state_next           = ARB_WAIT;
          last_next            = pick_idx;
          id_next              = pick_idx;
          wd_next              = '0;
          grant_next[pick_idx] = 1'b1;
          div_rst_next         = 1'b0;
          for (int unsigned i = 0; i < unsigned'(NUM_REQ); i++) begin
            if (pick_idx == IDX_W'(i)) begin
              lhs_next = req_lhs[i*DATA_WIDTH +: DATA_WIDTH];
              rhs_next = req_rhs[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
      ARB_WAIT: begin
        wd_next = wd + 1'b1;
        if (div_singular || div_complete || (wd == WD_W'(TIMEOUT - 1))) begin
          state_next          = ARB_DONE;
          resp_valid_next[id] = 1'b1;
          div_rst_next        = 1'b1;
          // Singular outranks complete, which outranks the watchdog.
          if (div_singular) begin
            resp_data_next = '0;
            sing_next      = 1'b1;
            tmo_next       = 1'b0;
          end else if (div_complete) begin
            resp_data_next = div_out;
            sing_next      = 1'b0;
            tmo_next       = 1'b0;
          end else begin
            resp_data_next = '0;
            sing_next      = 1'b0;
            tmo_next       = 1'b1;
          end
        end
      end
      ARB_DONE: begin
        sing_next    = 1'b0;
        tmo_next     = 1'b0;
        div_rst_next = 1'b1;
        state_next   = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

endmodule
